// File: rtl/shift_tx_ctrl.sv
// shift_tx_ctrl: frames a parallel word as start, WIDTH data bits LSB-first,
// and a stop bit. Each bit lasts DIV clocks. Words arrive via in_valid/in_ready.
//   clk, clr_n (async active-low), abort (sync frame abort)
//   in_valid, din[WIDTH-1:0] -> in_ready
//   sout (serial line, idles high), busy, done (1-cycle end-of-frame pulse)
module shift_tx_ctrl #(
  parameter int WIDTH = 4,
  parameter int DIV   = 4
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             abort,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] din,
  output logic             in_ready,
  output logic             sout,
  output logic             busy,
  output logic             done
);

  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] sr_q;
  logic [DW-1:0]    dcnt_q;
  logic [BW-1:0]    bcnt_q;
  logic             sout_q;
  logic             busy_q;
  logic             done_q;

  logic             dlast;
  logic             blast;
  logic             xfer;
  logic [WIDTH:0]   sr_ext;
  logic [WIDTH-1:0] sr_sh;

  assign dlast = (dcnt_q == DW'(DIV - 1));
  assign blast = (bcnt_q == BW'(WIDTH - 1));

  // The last stop-bit cycle also accepts, so back-to-back frames
  // have no idle-high gap between them.
  assign in_ready = (state_q == IDLE) ||
                    ((state_q == STOP) && dlast);
  assign xfer     = in_valid && in_ready && !abort;

  // Right shift with a 1 filled in; written to stay legal for WIDTH=1.
  assign sr_ext = {1'b1, sr_q} >> 1;
  assign sr_sh  = sr_ext[WIDTH-1:0];

  assign sout = sout_q;
  assign busy = busy_q;
  assign done = done_q;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q <= IDLE;
      sr_q    <= '0;
      dcnt_q  <= '0;
      bcnt_q  <= '0;
      sout_q  <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (abort) begin
        state_q <= IDLE;
        dcnt_q  <= '0;
        bcnt_q  <= '0;
        sout_q  <= 1'b1;
        busy_q  <= 1'b0;
      end else begin
        unique case (state_q)
          IDLE: begin
          end
          START: begin
            if (dlast) begin
              state_q <= DATA;
              dcnt_q  <= '0;
              sout_q  <= sr_q[0];
            end else begin
              dcnt_q <= dcnt_q + 1'b1;
            end
          end
          DATA: begin
            if (dlast) begin
              sr_q   <= sr_sh;
              dcnt_q <= '0;
              if (blast) begin
                state_q <= STOP;
                bcnt_q  <= '0;
                sout_q  <= 1'b1;
              end else begin
                bcnt_q <= bcnt_q + 1'b1;
                sout_q <= sr_sh[0];
              end
            end else begin
              dcnt_q <= dcnt_q + 1'b1;
            end
          end
          STOP: begin
            if (dlast) begin
              state_q <= IDLE;
              dcnt_q  <= '0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              dcnt_q <= dcnt_q + 1'b1;
            end
          end
        endcase
        // A new word overrides the end-of-frame return to IDLE.
        if (xfer) begin
          state_q <= START;
          sr_q    <= din;
          dcnt_q  <= '0;
          bcnt_q  <= '0;
          sout_q  <= 1'b0;
          busy_q  <= 1'b1;
        end
      end
    end
  end

endmodule
